// File: rtl/t05_flv_scan_if.sv
// ----------------------------------------------------------------------------
// t05_flv_scan_if
// Read port between the find-least-value scanner and the combined
// leaf/internal-node count table.
//
// Signals:
//   rd_req   - one-cycle read request (scanner -> table)
//   rd_addr  - table index qualified by rd_req (scanner -> table)
//   rd_valid - read data valid, 1 or more cycles after rd_req (table -> scanner)
//   rd_data  - count stored at the requested index (table -> scanner)
//
// Modports:
//   master - the scanner side
//   slave  - the table side
// ----------------------------------------------------------------------------
interface t05_flv_scan_if #(
    parameter int IDX_W = 8,
    parameter int CNT_W = 64
);
    logic             rd_req;
    logic [IDX_W-1:0] rd_addr;
    logic             rd_valid;
    logic [CNT_W-1:0] rd_data;

    modport master (
        output rd_req,
        output rd_addr,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_valid,
        output rd_data
    );
endinterface

// File: rtl/t05_flv_scan.sv
// ----------------------------------------------------------------------------
// t05_flv_scan
// Find-least-value stage of the Huffman tree builder. On start it walks the
// combined count table (leaves at 0..N_LEAF-1, then the live internal nodes)
// one entry at a time through a variable-latency read port and keeps the two
// smallest non-zero counts, their indices and their untruncated sum. One scan
// is run per merge step.
//
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   start               - begin a scan (honoured only while idle)
//   node_count          - live internal nodes for this scan, clamped to N_NODE
//   rd                  - table read port (master side)
//   busy                - scan in progress (any state other than idle)
//   done                - one-cycle pulse when the scan completes
//   least1 / least2     - indices of the smallest / second smallest entry
//   least1_node/2_node  - that index lies in the internal-node region
//   val1 / val2         - counts at least1 / least2 (all-ones when absent)
//   sum                 - merged count, CNT_W+1 bits wide
//   found               - non-zero entries seen, saturating at 2
//   single              - exactly one survivor: the tree is complete
//   none                - nothing non-zero in the table
// ----------------------------------------------------------------------------
module t05_flv_scan #(
    parameter  int N_LEAF = 128,
    parameter  int N_NODE = 128,
    parameter  int CNT_W  = 64,
    localparam int IDX_W  = $clog2(N_LEAF + N_NODE),
    localparam int NC_W   = $clog2(N_NODE + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NC_W-1:0]        node_count,
    t05_flv_scan_if.master         rd,
    output logic                   busy,
    output logic                   done,
    output logic [IDX_W-1:0]       least1,
    output logic [IDX_W-1:0]       least2,
    output logic                   least1_node,
    output logic                   least2_node,
    output logic [CNT_W-1:0]       val1,
    output logic [CNT_W-1:0]       val2,
    output logic [CNT_W:0]         sum,
    output logic [1:0]             found,
    output logic                   single,
    output logic                   none
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    // Count of non-zero entries only needs to distinguish 0, 1 and "2 or more".
    function automatic logic [1:0] sat_inc(input logic [1:0] f);
        return (f == 2'd2) ? 2'd2 : f + 2'd1;
    endfunction

    // Merged count; widened by one bit so two large counts never wrap.
    function automatic logic [CNT_W:0] merge_sum(input logic [1:0]       f,
                                                 input logic [CNT_W-1:0] v1,
                                                 input logic [CNT_W-1:0] v2);
        logic [CNT_W:0] s;
        case (f)
            2'd0:    s = '0;
            2'd1:    s = {1'b0, v1};
            default: s = {1'b0, v1} + {1'b0, v2};
        endcase
        return s;
    endfunction

    state_t           state_q,  state_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [IDX_W-1:0] last_q,   last_d;
    logic [IDX_W-1:0] least1_q, least1_d;
    logic [IDX_W-1:0] least2_q, least2_d;
    logic [CNT_W-1:0] val1_q,   val1_d;
    logic [CNT_W-1:0] val2_q,   val2_d;
    logic [1:0]       found_q,  found_d;
    logic [CNT_W:0]   sum_q,    sum_d;
    logic             single_q, single_d;
    logic             none_q,   none_d;

    logic [NC_W-1:0]  nc_eff;
    logic [IDX_W:0]   entries;

    // Number of entries to scan. One extra bit because a full table holds
    // 2**IDX_W entries; only the last index (entries-1) is stored.
    always_comb begin
        nc_eff  = (node_count > NC_W'(N_NODE)) ? NC_W'(N_NODE) : node_count;
        entries = (IDX_W+1)'(N_LEAF) + (IDX_W+1)'(nc_eff);
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        least1_d = least1_q;
        least2_d = least2_q;
        val1_d   = val1_q;
        val2_d   = val2_q;
        found_d  = found_q;
        sum_d    = sum_q;
        single_d = single_q;
        none_d   = none_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    last_d   = IDX_W'(entries - 1'b1);
                    idx_d    = '0;
                    val1_d   = '1;
                    val2_d   = '1;
                    found_d  = 2'd0;
                    least1_d = '0;
                    least2_d = '0;
                    state_d  = S_REQ;
                end
            end

            S_REQ: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (rd.rd_valid) begin
                    // Zero marks a wiped or unused slot. Strict less-than in
                    // ascending order keeps the lower index on ties, so a
                    // leaf beats an internal node of the same count.
                    if (rd.rd_data != '0) begin
                        found_d = sat_inc(found_q);
                        if (rd.rd_data < val1_q) begin
                            least2_d = least1_q;
                            val2_d   = val1_q;
                            least1_d = idx_q;
                            val1_d   = rd.rd_data;
                        end else if (rd.rd_data < val2_q) begin
                            least2_d = idx_q;
                            val2_d   = rd.rd_data;
                        end
                    end

                    if (idx_q == last_q) begin
                        // Final results include this last entry.
                        sum_d    = merge_sum(found_d, val1_d, val2_d);
                        single_d = (found_d == 2'd1);
                        none_d   = (found_d == 2'd0);
                        state_d  = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_REQ;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            last_q   <= '0;
            least1_q <= '0;
            least2_q <= '0;
            val1_q   <= '1;
            val2_q   <= '1;
            found_q  <= 2'd0;
            sum_q    <= '0;
            single_q <= 1'b0;
            none_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            least1_q <= least1_d;
            least2_q <= least2_d;
            val1_q   <= val1_d;
            val2_q   <= val2_d;
            found_q  <= found_d;
            sum_q    <= sum_d;
            single_q <= single_d;
            none_q   <= none_d;
        end
    end

    assign rd.rd_req   = (state_q == S_REQ);
    assign rd.rd_addr  = idx_q;

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign least1      = least1_q;
    assign least2      = least2_q;
    assign least1_node = (least1_q >= IDX_W'(N_LEAF));
    assign least2_node = (least2_q >= IDX_W'(N_LEAF));
    assign val1        = val1_q;
    assign val2        = val2_q;
    assign sum         = sum_q;
    assign found       = found_q;
    assign single      = single_q;
    assign none        = none_q;

endmodule

// File: tb/tb_t05_flv_scan.sv
// ----------------------------------------------------------------------------
// tb_t05_flv_scan
// Directed bench for t05_flv_scan with N_LEAF=8, N_NODE=8, CNT_W=16. A small
// table model answers read requests after a fixed or random latency; expected
// results are hand-computed per vector.
// ----------------------------------------------------------------------------
module tb_t05_flv_scan;

    localparam int N_LEAF = 8;
    localparam int N_NODE = 8;
    localparam int CNT_W  = 16;
    localparam int IDX_W  = 4;
    localparam int NC_W   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [NC_W-1:0]   node_count = '0;
    logic              busy, done;
    logic [IDX_W-1:0]  least1, least2;
    logic              least1_node, least2_node;
    logic [CNT_W-1:0]  val1, val2;
    logic [CNT_W:0]    sum;
    logic [1:0]        found;
    logic              single, none;

    t05_flv_scan_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) rd ();

    t05_flv_scan #(
        .N_LEAF (N_LEAF),
        .N_NODE (N_NODE),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .node_count  (node_count),
        .rd          (rd),
        .busy        (busy),
        .done        (done),
        .least1      (least1),
        .least2      (least2),
        .least1_node (least1_node),
        .least2_node (least2_node),
        .val1        (val1),
        .val2        (val2),
        .sum         (sum),
        .found       (found),
        .single      (single),
        .none        (none)
    );

    always #5 clk = ~clk;

    logic [CNT_W-1:0] tbl [16];
    bit               lat_rand = 1'b0;
    int               lat_fix  = 1;
    logic [IDX_W-1:0] rsp_addr;
    int               rsp_lat;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Table model: answers each request after rsp_lat cycles with a
    // one-cycle rd_valid pulse.
    initial begin
        rd.rd_valid = 1'b0;
        rd.rd_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            while (rd.rd_req === 1'b1) begin
                rsp_addr = rd.rd_addr;
                rsp_lat  = lat_rand ? int'($urandom_range(1, 5)) : lat_fix;
                repeat (rsp_lat) begin
                    @(posedge clk);
                    #1;
                end
                rd.rd_valid = 1'b1;
                rd.rd_data  = tbl[rsp_addr];
                @(posedge clk);
                #1;
                rd.rd_valid = 1'b0;
                rd.rd_data  = '0;
            end
        end
    end

    task automatic clear_tbl();
        for (int i = 0; i < 16; i++) tbl[i] = '0;
    endtask

    task automatic load_leaf_vec();
        clear_tbl();
        tbl[0] = 16'd0; tbl[1] = 16'd5; tbl[2] = 16'd3; tbl[3] = 16'd0;
        tbl[4] = 16'd9; tbl[5] = 16'd3; tbl[6] = 16'd7; tbl[7] = 16'd1;
    endtask

    // Starts a scan and returns in the done cycle (#1 after its edge).
    // done_cyc counts the start cycle as 0; -1 means done never came.
    task automatic run_scan(input logic [NC_W-1:0] nc, input bit poke,
                            output int done_cyc, output int reqs);
        int cyc;
        @(posedge clk);
        #1;
        node_count = nc;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        cyc      = 1;
        reqs     = 0;
        done_cyc = -1;
        while (cyc < 600) begin
            if (rd.rd_req === 1'b1) reqs++;
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            start = poke && (cyc == 3 || cyc == 10);
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic check_leaf_vec(input string p);
        chk({p, "_least1"}, 64'(least1), 64'd7);
        chk({p, "_val1"},   64'(val1),   64'd1);
        chk({p, "_least2"}, 64'(least2), 64'd2);
        chk({p, "_val2"},   64'(val2),   64'd3);
        chk({p, "_sum"},    64'(sum),    64'd4);
        chk({p, "_found"},  64'(found),  64'd2);
        chk({p, "_single"}, 64'(single), 64'd0);
        chk({p, "_none"},   64'(none),   64'd0);
        chk({p, "_l1node"}, 64'(least1_node), 64'd0);
    endtask

    initial begin
        int dc, nreq, guard;

        clear_tbl();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   64'(busy),      64'd0);
        chk("rst_done",   64'(done),      64'd0);
        chk("rst_rd_req", 64'(rd.rd_req), 64'd0);
        chk("rst_rd_addr",64'(rd.rd_addr),64'd0);
        chk("rst_least1", 64'(least1),    64'd0);
        chk("rst_least2", 64'(least2),    64'd0);
        chk("rst_val1",   64'(val1),      64'hFFFF);
        chk("rst_val2",   64'(val2),      64'hFFFF);
        chk("rst_sum",    64'(sum),       64'd0);
        chk("rst_found",  64'(found),     64'd0);
        chk("rst_single", 64'(single),    64'd0);
        chk("rst_none",   64'(none),      64'd0);
        rst = 1'b0;

        // Leaves only, 1-cycle latency: done in cycle 2*8+1.
        load_leaf_vec();
        lat_rand = 1'b0;
        lat_fix  = 1;
        run_scan(4'd0, 1'b0, dc, nreq);
        chk("leaf_done_cyc", 64'(dc), 64'd17);
        chk("leaf_reqs",     64'(nreq), 64'd8);
        check_leaf_vec("leaf");
        @(posedge clk);
        #1;
        chk("leaf_done_pulse", 64'(done),   64'd0);
        chk("leaf_idle",       64'(busy),   64'd0);
        chk("leaf_sum_hold",   64'(sum),    64'd4);
        chk("leaf_l1_hold",    64'(least1), 64'd7);

        // Tie against a node; nodes beyond node_count must not be read.
        clear_tbl();
        tbl[0] = 16'd4; tbl[8] = 16'd4; tbl[9] = 16'd2;
        for (int i = 10; i < 16; i++) tbl[i] = 16'd1;
        run_scan(4'd2, 1'b0, dc, nreq);
        chk("tie_done_cyc", 64'(dc),          64'd21);
        chk("tie_reqs",     64'(nreq),        64'd10);
        chk("tie_least1",   64'(least1),      64'd9);
        chk("tie_l1node",   64'(least1_node), 64'd1);
        chk("tie_least2",   64'(least2),      64'd0);
        chk("tie_l2node",   64'(least2_node), 64'd0);
        chk("tie_val1",     64'(val1),        64'd2);
        chk("tie_val2",     64'(val2),        64'd4);
        chk("tie_sum",      64'(sum),         64'd6);

        // Single survivor.
        clear_tbl();
        tbl[11] = 16'd100;
        for (int i = 12; i < 16; i++) tbl[i] = 16'd1;
        run_scan(4'd4, 1'b0, dc, nreq);
        chk("sgl_done_cyc", 64'(dc),          64'd25);
        chk("sgl_found",    64'(found),       64'd1);
        chk("sgl_single",   64'(single),      64'd1);
        chk("sgl_none",     64'(none),        64'd0);
        chk("sgl_least1",   64'(least1),      64'd11);
        chk("sgl_l1node",   64'(least1_node), 64'd1);
        chk("sgl_val1",     64'(val1),        64'd100);
        chk("sgl_val2",     64'(val2),        64'hFFFF);
        chk("sgl_sum",      64'(sum),         64'd100);

        // All-zero full table.
        clear_tbl();
        run_scan(4'd8, 1'b0, dc, nreq);
        chk("zero_done_cyc", 64'(dc),     64'd33);
        chk("zero_none",     64'(none),   64'd1);
        chk("zero_single",   64'(single), 64'd0);
        chk("zero_found",    64'(found),  64'd0);
        chk("zero_sum",      64'(sum),    64'd0);
        chk("zero_least1",   64'(least1), 64'd0);
        chk("zero_least2",   64'(least2), 64'd0);
        chk("zero_val1",     64'(val1),   64'hFFFF);

        // node_count above N_NODE is clamped; large counts must not wrap.
        clear_tbl();
        tbl[3]  = 16'hFFFE;
        tbl[15] = 16'hFFFD;
        run_scan(4'd15, 1'b0, dc, nreq);
        chk("clamp_reqs",   64'(nreq),        64'd16);
        chk("clamp_done",   64'(dc),          64'd33);
        chk("clamp_least1", 64'(least1),      64'd15);
        chk("clamp_l1node", 64'(least1_node), 64'd1);
        chk("clamp_least2", 64'(least2),      64'd3);
        chk("clamp_l2node", 64'(least2_node), 64'd0);
        chk("clamp_sum",    64'(sum),         64'h1FFFB);

        // Random 1-5 cycle latency with start pokes while busy.
        load_leaf_vec();
        lat_rand = 1'b1;
        run_scan(4'd0, 1'b1, dc, nreq);
        chk("rnd_done_seen", 64'(dc > 0),   64'd1);
        chk("rnd_min_cyc",   64'(dc >= 17), 64'd1);
        chk("rnd_reqs",      64'(nreq),     64'd8);
        check_leaf_vec("rnd");
        @(posedge clk);
        #1;
        chk("rnd_idle", 64'(busy), 64'd0);

        // Reset in the WAIT of entry 3; its rd_valid lands the cycle after.
        lat_rand = 1'b0;
        lat_fix  = 2;
        node_count = 4'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        guard = 0;
        while (!(rd.rd_req === 1'b1 && rd.rd_addr == 4'd3) && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("rstw_reached_e3", 64'(guard < 100), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rstw_busy",   64'(busy),      64'd0);
        chk("rstw_done",   64'(done),      64'd0);
        chk("rstw_rd_req", 64'(rd.rd_req), 64'd0);
        chk("rstw_found",  64'(found),     64'd0);
        chk("rstw_least1", 64'(least1),    64'd0);
        chk("rstw_least2", 64'(least2),    64'd0);
        chk("rstw_val1",   64'(val1),      64'hFFFF);
        chk("rstw_val2",   64'(val2),      64'hFFFF);
        chk("rstw_sum",    64'(sum),       64'd0);
        chk("rstw_single", 64'(single),    64'd0);
        chk("rstw_none",   64'(none),      64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rstw_still_idle", 64'(busy), 64'd0);

        // Fresh scan after the mid-scan reset.
        lat_fix = 1;
        run_scan(4'd0, 1'b0, dc, nreq);
        chk("fresh_done_cyc", 64'(dc),   64'd17);
        chk("fresh_reqs",     64'(nreq), 64'd8);
        check_leaf_vec("fresh");

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/t05_flv_scan.md
Name: t05_flv_scan

Overview:
- Parametrised successor to the team's find-least-value stage in the Huffman tree builder.
- On `start`, scans a combined table of leaf counts (character histogram) and internal-node counts through a request/valid read port with variable latency.
- Returns the two smallest non-zero entries, their values and their sum.
- Flags the single-survivor (tree complete) and empty cases explicitly.
- Runs under HTREE control: one scan per merge step.

Parameters:
- N_LEAF, 128, number of leaf entries at table indices 0..N_LEAF-1
- N_NODE, 128, maximum internal-node entries at indices N_LEAF..N_LEAF+N_NODE-1
- CNT_W, 64, width of each count value
- IDX_W (localparam), clog2(N_LEAF+N_NODE), table index width
- NC_W (localparam), clog2(N_NODE+1), node-count width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin scan; sampled only in IDLE
- node_count  in  NC_W  valid internal nodes this scan; latched at start; clamped to N_NODE
- rd_req  out  1  one-cycle read request
- rd_addr  out  IDX_W  table index for rd_req
- rd_valid  in  1  read data valid; any latency of 1 or more cycles after rd_req
- rd_data  in  CNT_W  count at rd_addr
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the scan completes
- least1  out  IDX_W  index of the smallest non-zero entry
- least2  out  IDX_W  index of the second smallest non-zero entry
- least1_node  out  1  least1 is at or above N_LEAF
- least2_node  out  1  least2 is at or above N_LEAF
- val1  out  CNT_W  value at least1
- val2  out  CNT_W  value at least2
- sum  out  CNT_W+1  merged count, never truncated
- found  out  2  number of non-zero entries seen, saturating at 2
- single  out  1  found==1 at done (tree complete)
- none  out  1  found==0 at done

Behaviour:
- Reset (synchronous, rst high at a clock edge):
  - State goes to IDLE; this applies from any state, including mid-scan.
  - rd_req=0, rd_addr=0, busy=0, done=0, least1=least2=0, least1_node=least2_node=0, val1=val2=all-ones, sum=0, found=0, single=0, none=0.
  - Any rd_valid arriving after reset is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: on start, latch E = N_LEAF + min(node_count, N_NODE). Set idx=0, val1=val2=all-ones, found=0, least1=least2=0. Go to REQ. Results from the previous scan hold until this start.
  - REQ: rd_req=1, rd_addr=idx for exactly one cycle. Go to WAIT.
  - WAIT: stay while rd_valid=0 (rd_req=0). On rd_valid, apply the compare. If idx==E-1, go to DONE; else idx+1 and go to REQ.
  - DONE: done=1 for one cycle. sum, single and none are valid in this cycle and hold afterwards. Go to IDLE.
- start while busy is ignored. rd_valid outside WAIT is ignored.
- Compare, in WAIT with rd_valid; strict less-than, scanned in ascending index order:
  - d==0: skip. The entry is wiped or empty and found is unchanged.
  - d<val1: least2<=least1, val2<=val1, least1<=idx, val1<=d.
  - else if d<val2: least2<=idx, val2<=d.
  - Every non-zero d increments found, saturating at 2.
  - Ties keep the lower index, so leaves win ties against nodes.
  - least*_node = (least* >= N_LEAF).
- sum:
  - found==2: val1+val2, zero-extended to CNT_W+1.
  - found==1: val1.
  - found==0: 0.
- single = (found==1) and none = (found==0); both are updated at DONE entry.
- Latency with 1-cycle read latency:
  - Entry i: REQ in cycle 2i+1, WAIT in cycle 2i+2, counting the start cycle as 0.
  - done asserts in cycle 2E+1. Each extra read-latency cycle adds 1 per entry.
- node_count=0 scans leaves only.
- A value of all-ones is treated as a normal count. Callers must not store it; it is used internally as the empty sentinel.

Test Plan:
- Leaves only, N_LEAF=8, node_count=0, counts [0,5,3,0,9,3,7,1], 1-cycle latency -> least1=7, val1=1; least2=2, val2=3; sum=4; found=2; done in cycle 17.
- Tie against a node: leaves [4,0,...,0], node 0 = 4, node 1 = 2, node_count=2 -> least1=N_LEAF+1 with least1_node=1; least2=0 (leaf wins the tie); sum=6.
- Single survivor: only node index N_LEAF+3 = 100, node_count=4 -> found=1, single=1, least1=N_LEAF+3, sum=100.
- All-zero table -> none=1, found=0, sum=0, least1=least2=0, done still pulses.
- Random rd_valid delay of 1-5 cycles per entry -> same results as the zero-stall run; rd_req is exactly one pulse per entry; start pulses during busy are ignored.
- rst asserted in the WAIT of entry 3, with rd_valid arriving the next cycle -> all outputs hold reset values and the state is IDLE. A fresh start then gives correct results.
